// File: rtl/conv3x3_dot_accum.sv
// conv3x3_dot_accum: streams TAPS (pixel, weight) beats for three channels in parallel,
// accumulates the signed per-channel products and presents the three dot products with
// a valid/ready handshake. Results stay stable until the consumer accepts them.
//
// Optional feature macro: CONV3X3_DOT_BIAS_EN
//   When defined, bias_c0..2 ports exist and each accumulator loads its bias (instead of
//   zero) when a window starts. Timing and FSM behaviour are identical in both builds.
module conv3x3_dot_accum #(
    parameter int unsigned TAPS  = 9,
    parameter int unsigned PIX_W = 8,
    parameter int unsigned WGT_W = 8,
    parameter int unsigned ACC_W = 21
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [PIX_W-1:0] pix_c0,
    input  logic [PIX_W-1:0] pix_c1,
    input  logic [PIX_W-1:0] pix_c2,
    input  logic [WGT_W-1:0] wgt_c0,
    input  logic [WGT_W-1:0] wgt_c1,
    input  logic [WGT_W-1:0] wgt_c2,
`ifdef CONV3X3_DOT_BIAS_EN
    input  logic [ACC_W-1:0] bias_c0,
    input  logic [ACC_W-1:0] bias_c1,
    input  logic [ACC_W-1:0] bias_c2,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] dot_D1,
    output logic [ACC_W-1:0] dot_D2,
    output logic [ACC_W-1:0] dot_D3,
    output logic             busy
);

    localparam int unsigned CntW = $clog2(TAPS + 1);
    // Unsigned pixel gets a zero sign bit, so the product needs one extra bit.
    localparam int unsigned PrdW = PIX_W + WGT_W + 1;

    typedef enum logic [1:0] {
        StIdle,
        StAccum,
        StHold
    } state_e;

    state_e           state_q;
    logic [CntW-1:0]  tap_cnt_q;
    logic             out_valid_q;
    logic             busy_q;

    logic [PIX_W-1:0]        pix_a  [3];
    logic [WGT_W-1:0]        wgt_a  [3];
    logic signed [PrdW-1:0]  prod   [3];
    logic signed [ACC_W-1:0] acc_q  [3];
    logic signed [ACC_W-1:0] acc_d  [3];
    logic signed [ACC_W-1:0] acc_init [3];

    logic start_acc;
    logic beat_acc;
    logic last_beat;

    assign pix_a[0] = pix_c0;
    assign pix_a[1] = pix_c1;
    assign pix_a[2] = pix_c2;
    assign wgt_a[0] = wgt_c0;
    assign wgt_a[1] = wgt_c1;
    assign wgt_a[2] = wgt_c2;

    // Value each accumulator takes when a window starts.
    always_comb begin
`ifdef CONV3X3_DOT_BIAS_EN
        acc_init[0] = $signed(bias_c0);
        acc_init[1] = $signed(bias_c1);
        acc_init[2] = $signed(bias_c2);
`else
        acc_init[0] = '0;
        acc_init[1] = '0;
        acc_init[2] = '0;
`endif
    end

    // Per-channel signed product, sign-extended and added to the running sum.
    always_comb begin
        for (int i = 0; i < 3; i++) begin
            prod[i]  = PrdW'($signed({1'b0, pix_a[i]})) * PrdW'($signed(wgt_a[i]));
            acc_d[i] = acc_q[i] + ACC_W'(prod[i]);
        end
    end

    // Handshake decode: start is honoured anywhere except HOLD without out_ready,
    // and a start always wins over a concurrent tap beat.
    always_comb begin
        start_acc = 1'b0;
        unique case (state_q)
            StIdle:  start_acc = start;
            StAccum: start_acc = start;
            StHold:  start_acc = start && out_ready;
            default: start_acc = 1'b0;
        endcase
        beat_acc  = (state_q == StAccum) && in_valid && !start;
        last_beat = beat_acc && (tap_cnt_q == CntW'(TAPS - 1));
    end

    // Control FSM with registered out_valid/busy and the tap counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            tap_cnt_q   <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        state_q   <= StAccum;
                        tap_cnt_q <= '0;
                        busy_q    <= 1'b1;
                    end
                end
                StAccum: begin
                    if (start) begin
                        tap_cnt_q <= '0;
                    end else if (in_valid) begin
                        tap_cnt_q <= tap_cnt_q + 1'b1;
                        if (last_beat) begin
                            state_q     <= StHold;
                            out_valid_q <= 1'b1;
                        end
                    end
                end
                StHold: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        if (start) begin
                            state_q   <= StAccum;
                            tap_cnt_q <= '0;
                        end else begin
                            state_q <= StIdle;
                            busy_q  <= 1'b0;
                        end
                    end
                end
                default: begin
                    state_q     <= StIdle;
                    tap_cnt_q   <= '0;
                    out_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    // Accumulators: load on window start, add on accepted beats, otherwise hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 3; i++) begin
                acc_q[i] <= '0;
            end
        end else if (start_acc) begin
            for (int i = 0; i < 3; i++) begin
                acc_q[i] <= acc_init[i];
            end
        end else if (beat_acc) begin
            for (int i = 0; i < 3; i++) begin
                acc_q[i] <= acc_d[i];
            end
        end
    end

    assign in_ready  = (state_q == StAccum);
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign dot_D1    = acc_q[0];
    assign dot_D2    = acc_q[1];
    assign dot_D3    = acc_q[2];

`ifndef SYNTHESIS
    // A presented result is never withdrawn or altered before it is accepted.
    a_hold_valid : assert property (@(posedge clk) disable iff (!rst_n)
        (out_valid && !out_ready) |=> out_valid);
    a_hold_stable : assert property (@(posedge clk) disable iff (!rst_n)
        (out_valid && !out_ready) |=> ($stable(dot_D1) && $stable(dot_D2) && $stable(dot_D3)));
    a_ready_excl : assert property (@(posedge clk) disable iff (!rst_n)
        !(in_ready && out_valid));
`endif

endmodule
